// File: rtl/smi_pkg.sv
// Shared constants, field widths and FSM encoding for the Clause-22 SMI/MDIO initiator.
package smi_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int PHY_W       = 5;
    localparam int REG_W       = 5;
    localparam int DATA_W      = 16;
    localparam int HDR_CELLS   = 14;
    localparam int TA_CELLS    = 2;
    localparam int FIELD_CELLS = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        HDR  = 3'd2,
        TA   = 3'd3,
        DATA = 3'd4,
        DONE = 3'd5
    } smi_state_t;

    function automatic int frameLen(input int preambleLen);
        return preambleLen + FIELD_CELLS;
    endfunction

endpackage

// File: rtl/smi_mdc_gen.sv
// MDC generator: one cell is 2*MDC_DIV clocks, low half first; strobes mark the
// clock edges that start a cell (fall) and that raise MDC (rise, used for sampling).
module smi_mdc_gen #(
    parameter int MDC_DIV = 25
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_run,
    output logic o_mdc,
    output logic o_fallStrobe,
    output logic o_riseStrobe
);

    localparam int CW = $clog2(2 * MDC_DIV);
    localparam logic [CW-1:0] L_HALF_END = CW'(MDC_DIV - 1);
    localparam logic [CW-1:0] L_CELL_END = CW'(2 * MDC_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_mdc;

    // Restarting on every accept pins the cell phase to the accept cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (i_start || !i_run) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (r_cnt == L_CELL_END) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == L_HALF_END) begin
                r_mdc <= 1'b1;
            end
        end
    end

    assign o_mdc        = r_mdc;
    assign o_riseStrobe = i_run && (r_cnt == L_HALF_END);
    assign o_fallStrobe = i_run && (r_cnt == L_CELL_END);

endmodule

// File: rtl/smi_master.sv
// Clause-22 SMI/MDIO management-station: serialises read/write frames on MDIO
// and returns a one-cycle response with read data and a turnaround-error flag.
module smi_master
    import smi_pkg::*;
#(
    parameter int MDC_DIV      = 25,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic              clk_125,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [PHY_W-1:0]  cmd_phy_addr,
    input  logic [REG_W-1:0]  cmd_reg_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_ta_err,
    output logic              busy,
    output logic              mdc,
    output logic              mdout,
    output logic              mdout_en,
    input  logic              mdin
);

    localparam bit         L_NO_PRE     = (PREAMBLE_LEN == 0);
    localparam logic [6:0] L_HDR_START  = 7'(PREAMBLE_LEN);
    localparam logic [6:0] L_TA_START   = 7'(PREAMBLE_LEN + HDR_CELLS);
    localparam logic [6:0] L_TA_CHECK   = 7'(PREAMBLE_LEN + HDR_CELLS + 1);
    localparam logic [6:0] L_DATA_START = 7'(PREAMBLE_LEN + HDR_CELLS + TA_CELLS);
    localparam logic [6:0] L_LAST       = 7'(frameLen(PREAMBLE_LEN) - 1);

    smi_state_t        r_state;
    logic [6:0]        r_cell;
    logic [31:0]       r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rdata;
    logic              r_write;
    logic              r_taErr;
    logic              r_rspTaErr;
    logic              r_mdout;
    logic              r_mdoutEn;

    logic              w_accept;
    logic              w_run;
    logic              w_fall;
    logic              w_rise;
    logic [6:0]        w_cellNext;
    logic [31:0]       w_frame;

    assign cmd_ready  = (r_state == IDLE) || (r_state == DONE);
    assign busy       = ~cmd_ready;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_run      = (r_state == PRE) || (r_state == HDR) || (r_state == TA) || (r_state == DATA);
    assign w_cellNext = r_cell + 7'd1;

    // Read frames carry all-ones in the TA/DATA slots; those cells are never driven.
    assign w_frame = {ST_CODE, (cmd_write ? OP_WRITE : OP_READ), cmd_phy_addr, cmd_reg_addr,
                      (cmd_write ? TA_WRITE : 2'b11), (cmd_write ? cmd_wdata : 16'hFFFF)};

    smi_mdc_gen #(
        .MDC_DIV(MDC_DIV)
    ) u_mdcGen (
        .i_clk       (clk_125),
        .i_rst       (rst),
        .i_start     (w_accept),
        .i_run       (w_run),
        .o_mdc       (mdc),
        .o_fallStrobe(w_fall),
        .o_riseStrobe(w_rise)
    );

    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cell     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rdata    <= '0;
            r_write    <= 1'b0;
            r_taErr    <= 1'b0;
            r_rspTaErr <= 1'b0;
            r_mdout    <= 1'b1;
            r_mdoutEn  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write   <= cmd_write;
                r_cell    <= '0;
                r_taErr   <= 1'b0;
                r_mdoutEn <= 1'b1;
                if (L_NO_PRE) begin
                    r_state <= HDR;
                    r_mdout <= w_frame[31];
                    r_tx    <= {w_frame[30:0], 1'b1};
                end else begin
                    r_state <= PRE;
                    r_mdout <= 1'b1;
                    r_tx    <= w_frame;
                end
            end else if (w_fall) begin
                if (r_cell == L_LAST) begin
                    r_state    <= DONE;
                    r_mdout    <= 1'b1;
                    r_mdoutEn  <= 1'b0;
                    r_rdata    <= r_write ? '0 : r_rx;
                    r_rspTaErr <= ~r_write & r_taErr;
                end else begin
                    r_cell    <= w_cellNext;
                    r_mdoutEn <= r_write | (w_cellNext < L_TA_START);
                    if ((r_state == PRE) && (w_cellNext != L_HDR_START)) begin
                        r_mdout <= 1'b1;
                    end else begin
                        r_mdout <= r_tx[31];
                        r_tx    <= {r_tx[30:0], 1'b1};
                    end
                    case (r_state)
                        PRE:     if (w_cellNext == L_HDR_START)  r_state <= HDR;
                        HDR:     if (w_cellNext == L_TA_START)   r_state <= TA;
                        TA:      if (w_cellNext == L_DATA_START) r_state <= DATA;
                        default: ;
                    endcase
                end
            end else if (r_state == DONE) begin
                r_state <= IDLE;
            end

            // Only the second TA cell is checked; the first is the bus hand-over.
            if (w_rise) begin
                if ((r_state == TA) && (r_cell == L_TA_CHECK)) begin
                    r_taErr <= mdin;
                end
                if (r_state == DATA) begin
                    r_rx <= {r_rx[DATA_W-2:0], mdin};
                end
            end
        end
    end

    assign rsp_valid  = (r_state == DONE);
    assign rsp_rdata  = r_rdata;
    assign rsp_ta_err = r_rspTaErr;
    assign mdout      = r_mdout;
    assign mdout_en   = r_mdoutEn;

endmodule

// File: tb/tb_smi_master.sv
// Directed self-checking bench for smi_master: default-parameter instance plus a
// short-frame instance (PREAMBLE_LEN=0, MDC_DIV=2).
module tb_smi_master;

    localparam int DIV_A = 25;
    localparam int DIV_B = 2;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst;

    logic        cmdValid, cmdWrite, mdin;
    logic [4:0]  cmdPhy, cmdReg;
    logic [15:0] cmdWdata;
    logic        cmdReady, rspValid, rspTaErr, busy, mdc, mdout, mdoutEn;
    logic [15:0] rspRdata;

    logic        cmdValidB, cmdWriteB, mdinB;
    logic [4:0]  cmdPhyB, cmdRegB;
    logic [15:0] cmdWdataB;
    logic        cmdReadyB, rspValidB, rspTaErrB, busyB, mdcB, mdoutB, mdoutEnB;
    logic [15:0] rspRdataB;

    always #5 clk = ~clk;

    smi_master dutA (
        .clk_125(clk), .rst(rst),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_write(cmdWrite),
        .cmd_phy_addr(cmdPhy), .cmd_reg_addr(cmdReg), .cmd_wdata(cmdWdata),
        .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_ta_err(rspTaErr),
        .busy(busy), .mdc(mdc), .mdout(mdout), .mdout_en(mdoutEn), .mdin(mdin)
    );

    smi_master #(.MDC_DIV(DIV_B), .PREAMBLE_LEN(0)) dutB (
        .clk_125(clk), .rst(rst),
        .cmd_valid(cmdValidB), .cmd_ready(cmdReadyB), .cmd_write(cmdWriteB),
        .cmd_phy_addr(cmdPhyB), .cmd_reg_addr(cmdRegB), .cmd_wdata(cmdWdataB),
        .rsp_valid(rspValidB), .rsp_rdata(rspRdataB), .rsp_ta_err(rspTaErrB),
        .busy(busyB), .mdc(mdcB), .mdout(mdoutB), .mdout_en(mdoutEnB), .mdin(mdinB)
    );

    // Presents one command for one edge; returns #1 after the accept edge (cycle T+1).
    task automatic issueA(input logic wr, input logic [4:0] phy, input logic [4:0] regAddr,
                          input logic [15:0] wd);
        cmdValid = 1'b1; cmdWrite = wr; cmdPhy = phy; cmdReg = regAddr; cmdWdata = wd;
        @(posedge clk); #1;
        cmdValid = 1'b0;
    endtask

    // Walks the 64 cells of a default frame from cycle T+1, driving mdin per cell and
    // recording outputs; returns #1 into cycle T+3201.
    task automatic captureFrame(input logic [63:0] resp, output logic [63:0] bits,
                                output logic [63:0] ens, output logic [63:0] mdcHigh,
                                output logic [63:0] mdcLow, output logic [63:0] rspEarly,
                                output logic [63:0] busyAll);
        for (int k = 0; k < 64; k++) begin
            mdin            = resp[63-k];
            mdcLow[63-k]    = mdc;
            busyAll[63-k]   = busy;
            repeat (DIV_A) @(posedge clk);
            #1;
            bits[63-k]      = mdout;
            ens[63-k]       = mdoutEn;
            mdcHigh[63-k]   = mdc;
            repeat (DIV_A - 1) @(posedge clk);
            #1;
            rspEarly[63-k]  = rspValid;
            @(posedge clk);
            #1;
        end
        mdin = 1'b1;
    endtask

    task automatic test_reset;
        checks++; if (mdc !== 1'b0)      begin failures++; $display("[TB] FAIL reset_mdc: got %b want 0", mdc); end
        checks++; if (mdout !== 1'b1)    begin failures++; $display("[TB] FAIL reset_mdout: got %b want 1", mdout); end
        checks++; if (mdoutEn !== 1'b0)  begin failures++; $display("[TB] FAIL reset_mdout_en: got %b want 0", mdoutEn); end
        checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmdReady); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rspValid); end
        checks++; if (rspRdata !== 16'h0) begin failures++; $display("[TB] FAIL reset_rsp_rdata: got %h want 0000", rspRdata); end
        checks++; if (rspTaErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_ta_err: got %b want 0", rspTaErr); end
        checks++; if ({mdcB, mdoutB, mdoutEnB, cmdReadyB} !== 4'b0101)
            begin failures++; $display("[TB] FAIL reset_b_outputs: got %b want 0101", {mdcB, mdoutB, mdoutEnB, cmdReadyB}); end
    endtask

    task automatic test_write;
        logic [63:0] bits, ens, mdcHigh, mdcLow, rspEarly, busyAll;
        issueA(1'b1, 5'h01, 5'h04, 16'hA5C3);
        captureFrame({64{1'b1}}, bits, ens, mdcHigh, mdcLow, rspEarly, busyAll);
        checks++; if (bits !== 64'hFFFFFFFF_5092A5C3) begin failures++; $display("[TB] FAIL write_bits: got %h want FFFFFFFF5092A5C3", bits); end
        checks++; if (ens !== {64{1'b1}})    begin failures++; $display("[TB] FAIL write_mdout_en: got %h want all ones", ens); end
        checks++; if (mdcHigh !== {64{1'b1}}) begin failures++; $display("[TB] FAIL write_mdc_high: got %h want all ones", mdcHigh); end
        checks++; if (mdcLow !== 64'h0)      begin failures++; $display("[TB] FAIL write_mdc_low: got %h want 0", mdcLow); end
        checks++; if (busyAll !== {64{1'b1}}) begin failures++; $display("[TB] FAIL write_busy: got %h want all ones", busyAll); end
        checks++; if (rspEarly !== 64'h0)    begin failures++; $display("[TB] FAIL write_rsp_early: got %h want 0", rspEarly); end
        checks++; if (rspValid !== 1'b1)     begin failures++; $display("[TB] FAIL write_rsp_valid_t3201: got %b want 1", rspValid); end
        checks++; if (cmdReady !== 1'b1)     begin failures++; $display("[TB] FAIL write_cmd_ready_done: got %b want 1", cmdReady); end
        checks++; if (rspRdata !== 16'h0)    begin failures++; $display("[TB] FAIL write_rsp_rdata: got %h want 0000", rspRdata); end
        checks++; if ({mdc, mdout, mdoutEn} !== 3'b010)
            begin failures++; $display("[TB] FAIL write_idle_lines: got %b want 010", {mdc, mdout, mdoutEn}); end
        @(posedge clk); #1;
        checks++; if (rspValid !== 1'b0)     begin failures++; $display("[TB] FAIL write_rsp_single: got %b want 0", rspValid); end
    endtask

    task automatic test_read;
        logic [63:0] bits, ens, mdcHigh, mdcLow, rspEarly, busyAll;
        issueA(1'b0, 5'h03, 5'h01, 16'hBEEF);
        captureFrame({32'hFFFFFFFF, 16'hFFFE, 16'h796D}, bits, ens, mdcHigh, mdcLow, rspEarly, busyAll);
        checks++; if ((bits & 64'hFFFFFFFF_FFFC0000) !== 64'hFFFFFFFF_61840000)
            begin failures++; $display("[TB] FAIL read_hdr_bits: got %h want FFFFFFFF61840000", bits & 64'hFFFFFFFF_FFFC0000); end
        checks++; if (ens !== 64'hFFFFFFFF_FFFC0000) begin failures++; $display("[TB] FAIL read_mdout_en: got %h want FFFFFFFFFFFC0000", ens); end
        checks++; if (rspEarly !== 64'h0) begin failures++; $display("[TB] FAIL read_rsp_early: got %h want 0", rspEarly); end
        checks++; if (rspValid !== 1'b1)  begin failures++; $display("[TB] FAIL read_rsp_valid: got %b want 1", rspValid); end
        checks++; if (rspRdata !== 16'h796D) begin failures++; $display("[TB] FAIL read_rdata: got %h want 796D", rspRdata); end
        checks++; if (rspTaErr !== 1'b0)  begin failures++; $display("[TB] FAIL read_ta_err: got %b want 0", rspTaErr); end
    endtask

    task automatic test_read_no_responder;
        logic [63:0] bits, ens, mdcHigh, mdcLow, rspEarly, busyAll;
        issueA(1'b0, 5'h07, 5'h02, 16'h0000);
        captureFrame({64{1'b1}}, bits, ens, mdcHigh, mdcLow, rspEarly, busyAll);
        checks++; if (rspValid !== 1'b1)     begin failures++; $display("[TB] FAIL noresp_rsp_valid: got %b want 1", rspValid); end
        checks++; if (rspRdata !== 16'hFFFF) begin failures++; $display("[TB] FAIL noresp_rdata: got %h want FFFF", rspRdata); end
        checks++; if (rspTaErr !== 1'b1)     begin failures++; $display("[TB] FAIL noresp_ta_err: got %b want 1", rspTaErr); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] bits, ens, mdcHigh, mdcLow, rspEarly, busyAll;
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdPhy = 5'h1F; cmdReg = 5'h0A; cmdWdata = 16'h0F0F;
        @(posedge clk); #1;
        // Next command (a read) is presented while the write is in flight.
        cmdWrite = 1'b0; cmdPhy = 5'h02; cmdReg = 5'h1F; cmdWdata = 16'h1111;
        captureFrame({64{1'b1}}, bits, ens, mdcHigh, mdcLow, rspEarly, busyAll);
        checks++; if (bits !== 64'hFFFFFFFF_5FAA0F0F) begin failures++; $display("[TB] FAIL b2b_write_bits: got %h want FFFFFFFF5FAA0F0F", bits); end
        checks++; if (rspValid !== 1'b1)  begin failures++; $display("[TB] FAIL b2b_rsp1_valid: got %b want 1", rspValid); end
        checks++; if (cmdReady !== 1'b1)  begin failures++; $display("[TB] FAIL b2b_ready_on_rsp: got %b want 1", cmdReady); end
        checks++; if (rspRdata !== 16'h0) begin failures++; $display("[TB] FAIL b2b_write_rdata: got %h want 0000", rspRdata); end
        @(posedge clk); #1;
        cmdValid = 1'b0; cmdWrite = 1'b1; cmdPhy = 5'h15; cmdReg = 5'h15; cmdWdata = 16'h5555;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_accept: got busy %b want 1", busy); end
        captureFrame({32'hFFFFFFFF, 16'hFFFE, 16'hC3A5}, bits, ens, mdcHigh, mdcLow, rspEarly, busyAll);
        checks++; if ((bits & 64'hFFFFFFFF_FFFC0000) !== 64'hFFFFFFFF_617C0000)
            begin failures++; $display("[TB] FAIL b2b_read_hdr: got %h want FFFFFFFF617C0000", bits & 64'hFFFFFFFF_FFFC0000); end
        checks++; if (rspValid !== 1'b1)     begin failures++; $display("[TB] FAIL b2b_rsp2_valid: got %b want 1", rspValid); end
        checks++; if (rspRdata !== 16'hC3A5) begin failures++; $display("[TB] FAIL b2b_read_rdata: got %h want C3A5", rspRdata); end
        @(posedge clk); #1;
        checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_no_queue: got ready %b want 1", cmdReady); end
    endtask

    task automatic test_reset_abort;
        logic [63:0] bits, ens, mdcHigh, mdcLow, rspEarly, busyAll;
        issueA(1'b1, 5'h11, 5'h11, 16'h1234);
        repeat (2 * DIV_A * 20 + DIV_A) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (mdc !== 1'b0)      begin failures++; $display("[TB] FAIL abort_mdc: got %b want 0", mdc); end
        checks++; if (mdoutEn !== 1'b0)  begin failures++; $display("[TB] FAIL abort_mdout_en: got %b want 0", mdoutEn); end
        checks++; if (mdout !== 1'b1)    begin failures++; $display("[TB] FAIL abort_mdout: got %b want 1", mdout); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
        checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL abort_rsp_valid: got %b want 0", rspValid); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issueA(1'b1, 5'h00, 5'h1F, 16'h8001);
        captureFrame({64{1'b1}}, bits, ens, mdcHigh, mdcLow, rspEarly, busyAll);
        checks++; if (bits !== 64'hFFFFFFFF_507E8001) begin failures++; $display("[TB] FAIL abort_next_bits: got %h want FFFFFFFF507E8001", bits); end
        checks++; if (rspEarly !== 64'h0) begin failures++; $display("[TB] FAIL abort_rsp_early: got %h want 0", rspEarly); end
        checks++; if (rspValid !== 1'b1)  begin failures++; $display("[TB] FAIL abort_next_rsp: got %b want 1", rspValid); end
    endtask

    task automatic test_short_frame;
        logic [31:0] bitsB, earlyB;
        cmdValidB = 1'b1; cmdWriteB = 1'b1; cmdPhyB = 5'h01; cmdRegB = 5'h04; cmdWdataB = 16'hA5C3;
        @(posedge clk); #1;
        cmdValidB = 1'b0;
        for (int k = 0; k < 32; k++) begin
            repeat (DIV_B) @(posedge clk);
            #1;
            bitsB[31-k] = mdoutB;
            repeat (DIV_B - 1) @(posedge clk);
            #1;
            earlyB[31-k] = rspValidB;
            @(posedge clk);
            #1;
        end
        checks++; if (bitsB[31] !== 1'b0)  begin failures++; $display("[TB] FAIL short_first_bit: got %b want 0", bitsB[31]); end
        checks++; if (bitsB !== 32'h5092A5C3) begin failures++; $display("[TB] FAIL short_bits: got %h want 5092A5C3", bitsB); end
        checks++; if (earlyB !== 32'h0)    begin failures++; $display("[TB] FAIL short_rsp_early: got %h want 0", earlyB); end
        checks++; if (rspValidB !== 1'b1)  begin failures++; $display("[TB] FAIL short_rsp_t129: got %b want 1", rspValidB); end
        checks++; if (rspRdataB !== 16'h0) begin failures++; $display("[TB] FAIL short_rdata: got %h want 0000", rspRdataB); end
    endtask

    initial begin
        rst = 1'b1;
        cmdValid = 1'b0; cmdWrite = 1'b0; cmdPhy = '0; cmdReg = '0; cmdWdata = '0; mdin = 1'b1;
        cmdValidB = 1'b0; cmdWriteB = 1'b0; cmdPhyB = '0; cmdRegB = '0; cmdWdataB = '0; mdinB = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("[TB] starting directed tests");
        test_reset;
        test_write;
        test_read;
        test_read_no_responder;
        test_back_to_back;
        test_reset_abort;
        test_short_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
